// File: rtl/axis64to128_packer_pkg.sv
// Shared widths, FSM states and keep constants for the 64->128 AXI-Stream packer.
package axis64to128_packer_pkg;

  localparam int unsigned DIN_W  = 64;
  localparam int unsigned DOUT_W = 128;
  localparam int unsigned KIN_W  = 8;
  localparam int unsigned KOUT_W = 16;

  localparam logic [KIN_W-1:0] KEEP_HALF_NONE = 8'h00;

  // HALF_EMPTY: no beat held; HALF_FULL: upper half waiting in the hold register
  typedef enum logic {
    HALF_EMPTY = 1'b0,
    HALF_FULL  = 1'b1
  } pack_state_e;

endpackage

// File: rtl/axis128_out_slice.sv
// 128-bit output register slice: holds one word with keep/last until the sink takes it.
module axis128_out_slice
  import axis64to128_packer_pkg::*;
(
  input  logic              rx_axis_uclk,
  input  logic              RxAxis_Rstn,
  input  logic              load_i,
  input  logic [DOUT_W-1:0] data_i,
  input  logic [KOUT_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              m_tready_i,
  output logic              m_tvalid_o,
  output logic [DOUT_W-1:0] m_tdata_o,
  output logic [KOUT_W-1:0] m_tkeep_o,
  output logic              m_tlast_o
);

  logic              valid_q;
  logic [DOUT_W-1:0] data_q;
  logic [KOUT_W-1:0] keep_q;
  logic              last_q;

  // Load a new word when offered (caller guarantees the slot is free or draining), else drop valid on take
  always_ff @(posedge rx_axis_uclk or negedge RxAxis_Rstn) begin
    if (!RxAxis_Rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (m_tready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;

endmodule

// File: rtl/axis64to128_packer.sv
// Packs pairs of 64-bit AXI-Stream beats into 128-bit words (first beat in the upper half).
// Optional packet counters are built when AXIS_PACKER_PKT_CNT_EN is defined.
module axis64to128_packer
  import axis64to128_packer_pkg::*;
#(
  parameter int DATA_IN_W = 64
) (
  input  logic                 rx_axis_uclk,
  input  logic                 RxAxis_Rstn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic [DATA_IN_W-1:0] s_tdata,
  input  logic [KIN_W-1:0]     s_tkeep,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [DOUT_W-1:0]    m_tdata,
  output logic [KOUT_W-1:0]    m_tkeep,
  input  logic                 CntClr,
  output logic [31:0]          RxPkg_Cnt,
  output logic [31:0]          TxPkg_Cnt
);

  if (DATA_IN_W != DIN_W) begin : g_bad_width
    $error("axis64to128_packer: DATA_IN_W must be 64");
  end

  pack_state_e       state_q, state_d;
  logic [DIN_W-1:0]  hold_data_q, hold_data_d;
  logic [KIN_W-1:0]  hold_keep_q, hold_keep_d;
  logic              rdy_q;
  logic              s_accept;
  logic              load;
  logic [DOUT_W-1:0] word_data;
  logic [KOUT_W-1:0] word_keep;
  logic              word_last;

  // rdy_q keeps s_tready low during reset and raises it on the first edge after release
  assign s_tready = rdy_q & (~m_tvalid | m_tready);
  assign s_accept = s_tvalid & s_tready;

  // Next-state and output-word selection for the half-word packing FSM
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    load        = 1'b0;
    word_data   = '0;
    word_keep   = '0;
    word_last   = 1'b0;
    if (s_accept) begin
      unique case (state_q)
        HALF_EMPTY: begin
          if (s_tlast) begin
            load      = 1'b1;
            word_data = {s_tdata, {DIN_W{1'b0}}};
            word_keep = {s_tkeep, KEEP_HALF_NONE};
            word_last = 1'b1;
          end else begin
            state_d     = HALF_FULL;
            hold_data_d = s_tdata;
            hold_keep_d = s_tkeep;
          end
        end
        HALF_FULL: begin
          load      = 1'b1;
          word_data = {hold_data_q, s_tdata};
          word_keep = {hold_keep_q, s_tkeep};
          word_last = s_tlast;
          state_d   = HALF_EMPTY;
        end
      endcase
    end
  end

  // FSM state, hold register and ready enable
  always_ff @(posedge rx_axis_uclk or negedge RxAxis_Rstn) begin
    if (!RxAxis_Rstn) begin
      state_q     <= HALF_EMPTY;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      rdy_q       <= 1'b1;
    end
  end

  axis128_out_slice u_out (
    .rx_axis_uclk (rx_axis_uclk),
    .RxAxis_Rstn  (RxAxis_Rstn),
    .load_i       (load),
    .data_i       (word_data),
    .keep_i       (word_keep),
    .last_i       (word_last),
    .m_tready_i   (m_tready),
    .m_tvalid_o   (m_tvalid),
    .m_tdata_o    (m_tdata),
    .m_tkeep_o    (m_tkeep),
    .m_tlast_o    (m_tlast)
  );

`ifdef AXIS_PACKER_PKT_CNT_EN
  logic [31:0] rx_cnt_q, tx_cnt_q;

  // Packet counters; clear beats a same-cycle increment, natural 32-bit wrap
  always_ff @(posedge rx_axis_uclk or negedge RxAxis_Rstn) begin
    if (!RxAxis_Rstn) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else if (CntClr) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (s_accept && s_tlast)             rx_cnt_q <= rx_cnt_q + 32'd1;
      if (m_tvalid && m_tready && m_tlast) tx_cnt_q <= tx_cnt_q + 32'd1;
    end
  end

  assign RxPkg_Cnt = rx_cnt_q;
  assign TxPkg_Cnt = tx_cnt_q;
`else
  logic unused_cntclr;
  assign unused_cntclr = CntClr;
  assign RxPkg_Cnt     = '0;
  assign TxPkg_Cnt     = '0;
`endif

endmodule

// File: tb/tb_axis64to128_packer.sv
// Directed self-checking bench for axis64to128_packer.
module tb_axis64to128_packer;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          m_tvalid, m_tready = 1'b0, m_tlast;
  logic [127:0]  m_tdata;
  logic [15:0]   m_tkeep;
  logic          cnt_clr = 1'b0;
  logic [31:0]   rx_cnt, tx_cnt;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  int unsigned   cyc = 0;
  int unsigned   last_acc_cyc = 0;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    int unsigned  c;
  } word_t;
  word_t got[$];

  axis64to128_packer #(.DATA_IN_W(64)) dut (
    .rx_axis_uclk (clk),
    .RxAxis_Rstn  (rstn),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .s_tdata      (s_tdata),
    .s_tkeep      (s_tkeep),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .CntClr       (cnt_clr),
    .RxPkg_Cnt    (rx_cnt),
    .TxPkg_Cnt    (tx_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every word the sink takes (handshake seen mid-cycle, transfer at next edge)
  always @(negedge clk)
    if (rstn && m_tvalid && m_tready) got.push_back('{m_tdata, m_tkeep, m_tlast, cyc});

  // One cycle: drive at posedge+1, sample accept at negedge, return at next posedge+1
  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic rdy, output logic acc);
    s_tvalid = v; s_tdata = d; s_tkeep = k; s_tlast = l; m_tready = rdy;
    @(negedge clk);
    acc = v & s_tready;
    if (acc) last_acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic rdy, output int unsigned acc_cyc);
    logic acc;
    int unsigned n;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin step(1'b1, d, k, l, rdy, acc); n++; end
    acc_cyc = last_acc_cyc;
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_beat_timeout data=%h accepted=0 required=1", d);
    end
  endtask

  task automatic idle(input int unsigned n, input logic rdy);
    logic acc;
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, rdy, acc);
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1; idle(1, 1'b1); cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({m_tvalid, m_tlast, m_tdata, m_tkeep, s_tready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got=%h required=0", {m_tvalid, m_tlast, m_tdata, m_tkeep, s_tready});
    end
    n_tests++;
    if ({rx_cnt, tx_cnt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_counters got=%h/%h required=0/0", rx_cnt, tx_cnt);
    end
    rstn = 1'b1;
    #1;
    n_tests++;
    if (s_tready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge got=%b required=0", s_tready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (s_tready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release got=%b required=1", s_tready);
    end
  endtask

  task automatic test_five_beat();
    int unsigned ac;
    logic [144:0] exp_w [3];
    exp_w[0] = {1'b0, 16'hFFFF, 64'd1, 64'd2};
    exp_w[1] = {1'b0, 16'hFFFF, 64'd3, 64'd4};
    exp_w[2] = {1'b1, 16'hFF00, 64'd5, 64'd0};
    got.delete();
    for (int unsigned i = 1; i <= 5; i++) send_beat(64'(i), 8'hFF, (i == 5), 1'b1, ac);
    idle(3, 1'b1);
    n_tests++;
    if (got.size() != 3) begin
      n_fail++; $display("FAIL five_beat_count got=%0d required=3", got.size());
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        n_tests++;
        if ({got[i].l, got[i].k, got[i].d} !== exp_w[i]) begin
          n_fail++; $display("FAIL five_beat_word%0d got=%h required=%h", i, {got[i].l, got[i].k, got[i].d}, exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_keep_last();
    int unsigned a0, a1;
    got.delete();
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b1, a0);
    send_beat(64'h5555_6666_7777_8888, 8'h0F, 1'b1, 1'b1, a1);
    idle(3, 1'b1);
    n_tests++;
    if (got.size() != 1) begin
      n_fail++; $display("FAIL keep_last_count got=%0d required=1", got.size());
    end else begin
      n_tests++;
      if ({got[0].l, got[0].k, got[0].d} !== {1'b1, 16'hFF0F, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}) begin
        n_fail++; $display("FAIL keep_last_word got=%h required=%h", {got[0].l, got[0].k, got[0].d},
                           {1'b1, 16'hFF0F, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888});
      end
      n_tests++;
      if (got[0].c != a1 + 1) begin
        n_fail++; $display("FAIL keep_last_latency got=%0d required=%0d", got[0].c - a1, 1);
      end
    end
  endtask

  task automatic test_keep_zero();
    int unsigned ac;
    got.delete();
    send_beat(64'hDEAD, 8'h00, 1'b0, 1'b1, ac);
    send_beat(64'hBEEF, 8'hFF, 1'b1, 1'b1, ac);
    idle(3, 1'b1);
    n_tests++;
    if (got.size() != 1 || {got[0].l, got[0].k, got[0].d} !== {1'b1, 16'h00FF, 64'hDEAD, 64'hBEEF}) begin
      n_fail++; $display("FAIL keep_zero got_n=%0d word=%h required=%h", got.size(),
                         (got.size() > 0) ? {got[0].l, got[0].k, got[0].d} : 145'h0, {1'b1, 16'h00FF, 64'hDEAD, 64'hBEEF});
    end
  endtask

  task automatic test_backpressure();
    int unsigned ac;
    logic acc;
    int unsigned bad_rdy, bad_out;
    bad_rdy = 0; bad_out = 0;
    got.delete();
    send_beat(64'd10, 8'hFF, 1'b0, 1'b0, ac);
    send_beat(64'd20, 8'hFF, 1'b0, 1'b0, ac);
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b1, 64'd30, 8'hFF, 1'b0, 1'b0, acc);
      if (acc) bad_rdy++;
      if ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== {1'b1, 1'b0, 16'hFFFF, 64'd10, 64'd20}) bad_out++;
    end
    n_tests++;
    if (bad_rdy != 0) begin
      n_fail++; $display("FAIL stall_ready_low accepted_cycles=%0d required=0", bad_rdy);
    end
    n_tests++;
    if (bad_out != 0) begin
      n_fail++; $display("FAIL stall_output_stable unstable_cycles=%0d required=0", bad_out);
    end
    send_beat(64'd30, 8'hFF, 1'b0, 1'b1, ac);
    send_beat(64'd40, 8'hFF, 1'b1, 1'b1, ac);
    idle(3, 1'b1);
    n_tests++;
    if (got.size() != 2 ||
        {got[0].l, got[0].k, got[0].d} !== {1'b0, 16'hFFFF, 64'd10, 64'd20} ||
        {got[1].l, got[1].k, got[1].d} !== {1'b1, 16'hFFFF, 64'd30, 64'd40}) begin
      n_fail++; $display("FAIL stall_release got_n=%0d required=2 words {10,20},{30,40}", got.size());
    end
  endtask

  task automatic test_back_to_back();
    localparam int unsigned N = 6;
    logic acc;
    int unsigned nacc, bad;
    nacc = 0; bad = 0;
    clear_counters();
    got.delete();
    for (int unsigned i = 0; i < N; i++) begin
      step(1'b1, 64'hA0 + 64'(i), 8'(8'h01 << i), 1'b1, 1'b1, acc);
      if (acc) nacc++;
    end
    idle(3, 1'b1);
    n_tests++;
    if (nacc != N || got.size() != N) begin
      n_fail++; $display("FAIL b2b_throughput accepted=%0d words=%0d required=%0d", nacc, got.size(), N);
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if ({got[i].l, got[i].k, got[i].d} !== {1'b1, 8'(8'h01 << i), 8'h00, 64'hA0 + 64'(i), 64'h0}) bad++;
        if (got[i].c != got[0].c + i) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++; $display("FAIL b2b_words bad_items=%0d required=0", bad);
      end
    end
    n_tests++;
`ifdef AXIS_PACKER_PKT_CNT_EN
    if (rx_cnt !== N || tx_cnt !== N) begin
      n_fail++; $display("FAIL b2b_counters got=%0d/%0d required=%0d/%0d", rx_cnt, tx_cnt, N, N);
    end
`else
    if (rx_cnt !== 32'h0 || tx_cnt !== 32'h0) begin
      n_fail++; $display("FAIL b2b_counters_tied got=%0d/%0d required=0/0", rx_cnt, tx_cnt);
    end
`endif
  endtask

  task automatic test_reset_midpacket();
    int unsigned ac;
    for (int unsigned i = 1; i <= 3; i++) send_beat(64'(i), 8'hFF, 1'b0, 1'b1, ac);
    idle(2, 1'b0);
    got.delete();
    s_tvalid = 1'b0; m_tready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({m_tvalid, s_tready} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_outputs got=%b required=00", {m_tvalid, s_tready});
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    send_beat(64'hA, 8'hFF, 1'b0, 1'b1, ac);
    send_beat(64'hB, 8'hFF, 1'b1, 1'b1, ac);
    idle(3, 1'b1);
    n_tests++;
    if (got.size() != 1 || {got[0].l, got[0].k, got[0].d} !== {1'b1, 16'hFFFF, 64'hA, 64'hB}) begin
      n_fail++; $display("FAIL midreset_new_packet got_n=%0d word=%h required=%h", got.size(),
                         (got.size() > 0) ? {got[0].l, got[0].k, got[0].d} : 145'h0, {1'b1, 16'hFFFF, 64'hA, 64'hB});
    end
    n_tests++;
`ifdef AXIS_PACKER_PKT_CNT_EN
    if (rx_cnt !== 32'd1 || tx_cnt !== 32'd1) begin
      n_fail++; $display("FAIL midreset_counters got=%0d/%0d required=1/1", rx_cnt, tx_cnt);
    end
`else
    if (rx_cnt !== 32'h0 || tx_cnt !== 32'h0) begin
      n_fail++; $display("FAIL midreset_counters_tied got=%0d/%0d required=0/0", rx_cnt, tx_cnt);
    end
`endif
  endtask

`ifdef AXIS_PACKER_PKT_CNT_EN
  task automatic test_counters();
    int unsigned ac;
    force dut.rx_cnt_q = 32'hFFFF_FFFF;
    force dut.tx_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.rx_cnt_q;
    release dut.tx_cnt_q;
    send_beat(64'h1, 8'hFF, 1'b1, 1'b1, ac);
    idle(2, 1'b1);
    n_tests++;
    if (rx_cnt !== 32'h0 || tx_cnt !== 32'h0) begin
      n_fail++; $display("FAIL cnt_wrap got=%h/%h required=0/0", rx_cnt, tx_cnt);
    end
    send_beat(64'h2, 8'hFF, 1'b1, 1'b1, ac);
    idle(2, 1'b1);
    cnt_clr = 1'b1;
    send_beat(64'h3, 8'hFF, 1'b1, 1'b1, ac);
    idle(1, 1'b1);
    cnt_clr = 1'b0;
    idle(1, 1'b1);
    n_tests++;
    if (rx_cnt !== 32'h0 || tx_cnt !== 32'h0) begin
      n_fail++; $display("FAIL cnt_clr_priority got=%h/%h required=0/0", rx_cnt, tx_cnt);
    end
  endtask
`else
  task automatic test_counters();
    int unsigned ac;
    cnt_clr = 1'b1;
    send_beat(64'h3, 8'hFF, 1'b1, 1'b1, ac);
    idle(2, 1'b1);
    cnt_clr = 1'b0;
    n_tests++;
    if (rx_cnt !== 32'h0 || tx_cnt !== 32'h0) begin
      n_fail++; $display("FAIL cnt_disabled got=%h/%h required=0/0", rx_cnt, tx_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_five_beat();
    test_keep_last();
    test_keep_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midpacket();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis64to128_packer.md
AXIS64TO128_PACKER -- requirements
Module: axis64to128_packer

Interface
REQ-001 SHALL have parameter DATA_IN_W, default 64, input tdata width; the only legal value is 64.
REQ-002 SHALL have port rx_axis_uclk, input, 1, the single clock for all logic.
REQ-003 SHALL have port RxAxis_Rstn, input, 1, reset: asynchronous, active-low; clock rx_axis_uclk.
REQ-004 SHALL have ports s_tvalid/s_tready/s_tlast, in/out/in, 1 each, 64-bit slave handshake.
REQ-005 SHALL have ports s_tdata, input, 64, and s_tkeep, input, 8, slave data and byte enables.
REQ-006 SHALL have ports m_tvalid/m_tready/m_tlast, out/in/out, 1 each, 128-bit master handshake.
REQ-007 SHALL have ports m_tdata, output, 128, and m_tkeep, output, 16, master data and byte enables.
REQ-008 SHALL have ports CntClr, input, 1; RxPkg_Cnt and TxPkg_Cnt, output, 32 each.

Function
REQ-009 SHALL pack two consecutive accepted 64-bit beats into one 128-bit word: first beat in m_tdata[127:64] and m_tkeep[15:8]; second beat in [63:0] and [7:0].
REQ-010 SHALL use FSM states HALF_EMPTY (no beat held) and HALF_FULL (upper half held in hold register).
REQ-011 SHALL accept a beat when s_tvalid and s_tready are both high; s_tready = ~m_tvalid | m_tready, registered outputs only.
REQ-012 When in HALF_EMPTY, an accepted beat with s_tlast=0 SHALL be stored and the FSM SHALL go to HALF_FULL with no output.
REQ-013 When in HALF_EMPTY, an accepted beat with s_tlast=1 SHALL emit {s_tdata, 64'h0}, m_tkeep={s_tkeep, 8'h00}, m_tlast=1 next cycle; the FSM SHALL stay in HALF_EMPTY.
REQ-014 When in HALF_FULL, an accepted beat SHALL emit {hold, s_tdata}, m_tkeep={hold_keep, s_tkeep}, m_tlast=s_tlast next cycle, and the FSM SHALL go to HALF_EMPTY.
REQ-015 Latency from accepting the completing beat to m_tvalid SHALL be exactly 1 cycle.
REQ-016 m_tdata/m_tkeep/m_tlast SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-017 A beat arriving in the same cycle that the output word is consumed (m_tready=1) SHALL be accepted without a bubble, giving full throughput of one 64-bit beat per cycle.
REQ-018 s_tkeep SHALL pass through unmodified; s_tkeep=8'h00 on a non-last beat SHALL still be packed.
REQ-019 RxPkg_Cnt SHALL increment on each accepted beat with s_tlast=1; TxPkg_Cnt SHALL increment on each m_tvalid&m_tready&m_tlast; both SHALL wrap 32'hFFFFFFFF->0.
REQ-020 CntClr=1 SHALL clear both counters synchronously and take priority over a simultaneous increment.

Reset
REQ-021 While RxAxis_Rstn=0, m_tvalid, m_tlast, m_tdata, m_tkeep, s_tready, hold registers and both counters SHALL be 0, and the FSM SHALL be in HALF_EMPTY.
REQ-022 Reset asserted mid-packet SHALL discard the held half-word and any pending output word; no partial word SHALL be emitted after release.
REQ-023 s_tready SHALL go high on the first rising edge after RxAxis_Rstn deasserts.

Configuration
REQ-024 Macro AXIS_PACKER_PKT_CNT_EN defined: REQ-019/020 counters SHALL be implemented.
REQ-025 Macro undefined: RxPkg_Cnt and TxPkg_Cnt SHALL be tied to 32'h0, CntClr SHALL be ignored, and the ports SHALL remain present.

Structure
REQ-026 A shared package SHALL hold the FSM state constants, the widths 64/128/8/16, and KEEP_HALF_NONE=8'h00.
REQ-027 The output register stage SHALL be one sub-module, axis128_out_slice (valid/ready register with data, keep and last).

Verification
REQ-028 5-beat packet, m_tready=1, data 1..5, keep FF on all beats: 3 words {1,2},{3,4},{5,0}; keep FFFF, FFFF, FF00; tlast only on word 3.
REQ-029 2-beat packet, last keep 8'h0F: 1 word, keep 16'hFF0F, tlast=1, 1 cycle after beat 2.
REQ-030 m_tready=0 for 10 cycles during a packet: s_tready low once the word is pending, output stable, no loss or duplication on release.
REQ-031 Back-to-back 1-beat packets, continuous valid/ready: 1 word per beat, each with keep {k,8'h00} and tlast=1; RxPkg_Cnt=TxPkg_Cnt=N.
REQ-032 Reset pulse after beat 3 of 7, then a new 2-beat packet: only the new packet's word appears, with counters restarted from 0.
REQ-033 With AXIS_PACKER_PKT_CNT_EN, counter preset near 32'hFFFFFFFF and CntClr coincident with a tlast: wrap to 0 as expected, and CntClr wins, leaving count 0.
